// File: rtl/peripheral_dbg_pu_or1k_spr_slave.sv
// Responder end of the OR1K SPR debug bus on the CPU side.
// Decodes strobed SPR accesses to the debug-unit bank (DMR1, DMR2, DSR, DRR),
// inserts WAIT_CYCLES wait states, then acknowledges for a single cycle.
// Debug events qualified by DSR are latched into DRR, which drives the CPU stall.
// Ports:
//   cpu_clk_i, cpu_rst_ni          clock, async active-low reset
//   spr_addr_i/data_i/stb_i/we_i   access request from the debug bus
//   spr_data_o, spr_ack_o          registered read data and ack pulse
//   dbg_event_i                    debug event pulses, one per DSR/DRR bit
//   dmr1_o, dmr2_o, dsr_o, drr_o   register contents
//   cpu_stall_o                    stall request, OR of DRR
module peripheral_dbg_pu_or1k_spr_slave #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned SPR_GROUP   = 6
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_ni,
    input  logic [31:0] spr_addr_i,
    input  logic [31:0] spr_data_i,
    output logic [31:0] spr_data_o,
    input  logic        spr_stb_i,
    input  logic        spr_we_i,
    output logic        spr_ack_o,
    input  logic [13:0] dbg_event_i,
    output logic [31:0] dmr1_o,
    output logic [31:0] dmr2_o,
    output logic [13:0] dsr_o,
    output logic [13:0] drr_o,
    output logic        cpu_stall_o
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned GRP_W = 5;
    localparam logic [10:0] IDX_DMR1 = 11'h010;
    localparam logic [10:0] IDX_DMR2 = 11'h011;
    localparam logic [10:0] IDX_DSR  = 11'h014;
    localparam logic [10:0] IDX_DRR  = 11'h015;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        dmr1_q, dmr1_d;
    logic [31:0]        dmr2_q, dmr2_d;
    logic [13:0]        dsr_q, dsr_d;
    logic [13:0]        drr_q, drr_d;

    // Access being committed this edge; with zero wait states it comes straight from the inputs.
    logic               commit;
    logic [15:0]        acc_addr;
    logic               acc_we;
    logic [31:0]        acc_data;
    logic               hit;
    logic [31:0]        rd_val;
    logic [13:0]        drr_clr;

    // Upper address bits play no part in the decode.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^spr_addr_i[31:16];

    // Access sequencing: capture in IDLE, count wait states, pulse ack.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        commit   = 1'b0;
        acc_addr = addr_q;
        acc_we   = we_q;
        acc_data = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (spr_stb_i) begin
                    addr_d   = spr_addr_i[15:0];
                    we_d     = spr_we_i;
                    wdata_d  = spr_data_i;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    acc_addr = spr_addr_i[15:0];
                    acc_we   = spr_we_i;
                    acc_data = spr_data_i;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACK;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!spr_stb_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register bank: decode, write commit, read capture and event latching.
    always_comb begin
        ack_d   = commit;
        rdata_d = rdata_q;
        dmr1_d  = dmr1_q;
        dmr2_d  = dmr2_q;
        dsr_d   = dsr_q;
        drr_clr = '0;
        hit     = (acc_addr[15:11] == GRP_W'(SPR_GROUP));
        rd_val  = '0;
        if (hit) begin
            case (acc_addr[10:0])
                IDX_DMR1: rd_val = dmr1_q;
                IDX_DMR2: rd_val = dmr2_q;
                IDX_DSR:  rd_val = {18'b0, dsr_q};
                IDX_DRR:  rd_val = {18'b0, drr_q};
                default:  rd_val = '0;
            endcase
        end
        if (commit) begin
            if (!acc_we) begin
                rdata_d = rd_val;
            end else if (hit) begin
                case (acc_addr[10:0])
                    IDX_DMR1: dmr1_d  = acc_data;
                    IDX_DMR2: dmr2_d  = acc_data;
                    IDX_DSR:  dsr_d   = acc_data[13:0];
                    IDX_DRR:  drr_clr = acc_data[13:0];
                    default:  ;
                endcase
            end
        end
        // Event set overrides a same-edge clear; qualified by DSR before the edge.
        drr_d = (drr_q & ~drr_clr) | (dbg_event_i & dsr_q);
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            dmr1_q  <= '0;
            dmr2_q  <= '0;
            dsr_q   <= '0;
            drr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            dmr1_q  <= dmr1_d;
            dmr2_q  <= dmr2_d;
            dsr_q   <= dsr_d;
            drr_q   <= drr_d;
        end
    end

    assign spr_ack_o   = ack_q;
    assign spr_data_o  = rdata_q;
    assign dmr1_o      = dmr1_q;
    assign dmr2_o      = dmr2_q;
    assign dsr_o       = dsr_q;
    assign drr_o       = drr_q;
    assign cpu_stall_o = |drr_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_spr_slave.sv
// Self-checking bench for peripheral_dbg_pu_or1k_spr_slave with three wait states.
module tb_peripheral_dbg_pu_or1k_spr_slave;

    localparam int unsigned W   = 3;
    localparam int unsigned GRP = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] spr_addr_i;
    logic [31:0] spr_data_i;
    logic [31:0] spr_data_o;
    logic        spr_stb_i;
    logic        spr_we_i;
    logic        spr_ack_o;
    logic [13:0] dbg_event_i;
    logic [31:0] dmr1_o;
    logic [31:0] dmr2_o;
    logic [13:0] dsr_o;
    logic [13:0] drr_o;
    logic        cpu_stall_o;

    peripheral_dbg_pu_or1k_spr_slave #(
        .WAIT_CYCLES (W),
        .SPR_GROUP   (GRP)
    ) dut (
        .cpu_clk_i   (clk),
        .cpu_rst_ni  (rst_n),
        .spr_addr_i  (spr_addr_i),
        .spr_data_i  (spr_data_i),
        .spr_data_o  (spr_data_o),
        .spr_stb_i   (spr_stb_i),
        .spr_we_i    (spr_we_i),
        .spr_ack_o   (spr_ack_o),
        .dbg_event_i (dbg_event_i),
        .dmr1_o      (dmr1_o),
        .dmr2_o      (dmr2_o),
        .dsr_o       (dsr_o),
        .drr_o       (drr_o),
        .cpu_stall_o (cpu_stall_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_dmr1, m_dmr2, m_rdata;
    logic [13:0] m_dsr, m_drr;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[15:11] != 5'(GRP)) return 32'h0;
        case (a[10:0])
            11'h010: return m_dmr1;
            11'h011: return m_dmr2;
            11'h014: return {18'b0, m_dsr};
            11'h015: return {18'b0, m_drr};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        if (a[15:11] == 5'(GRP)) begin
            case (a[10:0])
                11'h010: m_dmr1 = d;
                11'h011: m_dmr2 = d;
                11'h014: m_dsr  = d[13:0];
                11'h015: m_drr  = m_drr & ~d[13:0];
                default: ;
            endcase
        end
    endtask

    task automatic m_reset();
        m_dmr1 = '0; m_dmr2 = '0; m_dsr = '0; m_drr = '0; m_rdata = '0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_dmr1"},  dmr1_o, m_dmr1);
        check({tag, "_dmr2"},  dmr2_o, m_dmr2);
        check({tag, "_dsr"},   32'(dsr_o), 32'(m_dsr));
        check({tag, "_drr"},   32'(drr_o), 32'(m_drr));
        check({tag, "_stall"}, 32'(cpu_stall_o), 32'(|m_drr));
        check({tag, "_rdata"}, spr_data_o, m_rdata);
    endtask

    // One access with strobe held until ack; ev pulses on the commit edge.
    task automatic access(input string tag, input logic [31:0] a, input logic we,
                          input logic [31:0] d, input logic [13:0] ev, input bit scramble);
        logic [13:0] set_bits;
        spr_addr_i = a; spr_data_i = d; spr_we_i = we; spr_stb_i = 1'b1;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            if (k == int'(W) + 1) dbg_event_i = ev;
            if (k == 2 && scramble) begin
                spr_addr_i = $urandom;
                spr_data_i = $urandom;
            end
            @(negedge clk);
            dbg_event_i = '0;
            check({tag, "_ack"}, 32'(spr_ack_o), (k == int'(W) + 1) ? 32'd1 : 32'd0);
        end
        spr_stb_i = 1'b0;
        set_bits = ev & m_dsr;
        if (!we) m_rdata = m_read(a);
        else     m_write(a, d);
        m_drr = m_drr | set_bits;
        check_regs(tag);
        @(negedge clk);
        check({tag, "_ackw"}, 32'(spr_ack_o), 32'd0);
    endtask

    // Write aborted by dropping strobe after n wait cycles.
    task automatic abort_write(input logic [31:0] a, input logic [31:0] d, input int n);
        spr_addr_i = a; spr_data_i = d; spr_we_i = 1'b1; spr_stb_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("abort_ack_hi", 32'(spr_ack_o), 32'd0);
        end
        spr_stb_i = 1'b0;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("abort_ack_lo", 32'(spr_ack_o), 32'd0);
        end
        check_regs("abort");
    endtask

    task automatic event_cycles(input int n);
        logic [13:0] ev;
        for (int i = 0; i < n; i++) begin
            ev = 14'($urandom);
            if ($urandom_range(0, 1) == 0) ev = '0;
            dbg_event_i = ev;
            @(negedge clk);
            m_drr = m_drr | (ev & m_dsr);
            check("evt_drr",   32'(drr_o), 32'(m_drr));
            check("evt_stall", 32'(cpu_stall_o), 32'(|m_drr));
        end
        dbg_event_i = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[15:11] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(GRP);
        case ($urandom_range(0, 4))
            0: a[10:0] = 11'h010;
            1: a[10:0] = 11'h011;
            2: a[10:0] = 11'h014;
            3: a[10:0] = 11'h015;
            default: a[10:0] = 11'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        rst_n = 1'b0;
        spr_addr_i = '0; spr_data_i = '0; spr_stb_i = 1'b0; spr_we_i = 1'b0;
        dbg_event_i = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_regs("rst");
        check("rst_ack", 32'(spr_ack_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read DMR1
        access("wr_dmr1", 32'h0000_3010, 1'b1, 32'hDEAD_BEEF, '0, 1'b0);
        check("dmr1_const", dmr1_o, 32'hDEAD_BEEF);
        access("rd_dmr1", 32'h0000_3010, 1'b0, 32'h0, '0, 1'b0);
        check("rd_dmr1_const", spr_data_o, 32'hDEAD_BEEF);

        // Misses and zero-extension
        access("miss_rd", 32'h0000_3000, 1'b0, 32'h0, '0, 1'b0);
        access("miss_wr", 32'h0000_2010, 1'b1, 32'h1234_5678, '0, 1'b0);
        access("wr_dsr",  32'h0000_3014, 1'b1, 32'hFFFF_FFFF, '0, 1'b0);
        access("rd_dsr",  32'h0000_3014, 1'b0, 32'h0, '0, 1'b0);
        check("dsr_zext", spr_data_o, 32'h0000_3FFF);

        // Event latch, stall and clear
        access("dsr8", 32'h0000_3014, 1'b1, 32'h8, '0, 1'b0);
        dbg_event_i = 14'h000C;
        @(negedge clk);
        dbg_event_i = '0;
        m_drr = m_drr | (14'h000C & m_dsr);
        check("ev_drr", 32'(drr_o), 32'h8);
        check("ev_stall", 32'(cpu_stall_o), 32'd1);
        access("clr_drr", 32'h0000_3015, 1'b1, 32'h8, '0, 1'b0);
        check("clr_stall", 32'(cpu_stall_o), 32'd0);

        // Set beats clear on the same edge
        access("set_clr", 32'h0000_3015, 1'b1, 32'h8, 14'h0008, 1'b0);
        check("set_wins", 32'(drr_o), 32'h8);

        // Abort then normal access
        access("wr_dmr2", 32'h0000_3011, 1'b1, 32'h0BAD_F00D, '0, 1'b0);
        abort_write(32'h0000_3011, 32'h5555_AAAA, 2);
        access("after_abort", 32'h0000_3011, 1'b1, 32'h1357_9BDF, '0, 1'b0);

        // Reset in the middle of a wait
        spr_addr_i = 32'h0000_3010; spr_data_i = 32'hCAFE_F00D; spr_we_i = 1'b1; spr_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_regs("midrst");
        check("midrst_ack", 32'(spr_ack_o), 32'd0);
        spr_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < int'(W) + 2; k++) begin
            @(negedge clk);
            check("postrst_ack", 32'(spr_ack_o), 32'd0);
        end
        check_regs("postrst");

        // Randomized accesses mixed with event traffic
        for (int i = 0; i < 80; i++) begin
            access("rnd", rand_addr(), 1'($urandom), $urandom,
                   ($urandom_range(0, 2) == 0) ? 14'($urandom) : 14'h0, 1'b1);
            if ($urandom_range(0, 3) == 0) event_cycles(int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
